// File: rtl/mips_debug_ctrl.sv
// Host-side debug sequencer: assembles UART bytes into program-memory writes, runs/steps the core, reports status.
// All outputs registered, commands decode in one cycle; report bytes are paced by I_TX_BUSY, bytes arriving while busy are dropped.
module mips_debug_ctrl #(
  parameter int unsigned MAX_WORDS = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [7:0]  CMD_LOAD  = 8'h4C,
  parameter logic [7:0]  CMD_RUN   = 8'h43,
  parameter logic [7:0]  CMD_STEP  = 8'h53,
  parameter logic [7:0]  CMD_RST   = 8'h52
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  I_RX_DATA,
  input  logic        I_RX_VALID,
  input  logic        I_TX_BUSY,
  output logic [7:0]  O_TX_DATA,
  output logic        O_TX_START,
  input  logic        I_MIPS_FINISHED,
  input  logic [31:0] I_MIPS_PC,
  output logic        O_MIPS_RESET,
  output logic        O_MIPS_EN,
  output logic        O_MIPS_WrPM,
  output logic [31:0] O_MIPS_WrDataPM,
  output logic [31:0] O_MIPS_WrDataPMAddr,
  output logic [2:0]  O_STATE
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_BYTE  = 3'd1,
    S_LOAD_WRITE = 3'd2,
    S_RUN        = 3'd3,
    S_STEP       = 3'd4,
    S_TX_SEND    = 3'd5,
    S_TX_WAIT    = 3'd6
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0] r_idx, w_idx_nxt;
  logic [31:0] r_cycles, w_cycles_nxt;
  logic [63:0] r_tx_buf, w_tx_buf_nxt;
  logic [3:0]  r_tx_left, w_tx_left_nxt;
  logic        r_tx_skip, w_tx_skip_nxt;
  logic        r_stepped, w_stepped_nxt;
  logic        r_loaded, w_loaded_nxt;
  logic        r_mips_reset, w_mips_reset_nxt;
  logic        r_mips_en, w_mips_en_nxt;
  logic        r_wrpm, w_wrpm_nxt;
  logic [31:0] r_wrdata, w_wrdata_nxt;
  logic [31:0] r_wraddr, w_wraddr_nxt;
  logic        r_tx_start, w_tx_start_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;

  logic [31:0] w_word_shift;
  logic [31:0] w_idx_inc;
  logic [31:0] w_cycles_inc;
  logic        w_load_done;

  assign w_word_shift = {r_word[23:0], I_RX_DATA};
  assign w_idx_inc    = r_idx + 32'd1;
  assign w_cycles_inc = (r_cycles == 32'hFFFFFFFF) ? r_cycles : r_cycles + 32'd1;
  assign w_load_done  = (r_wrdata == HALT_WORD) || (w_idx_inc == MAX_W);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_byte_cnt   <= '0;
      r_idx        <= '0;
      r_cycles     <= '0;
      r_tx_buf     <= '0;
      r_tx_left    <= '0;
      r_tx_skip    <= 1'b0;
      r_stepped    <= 1'b0;
      r_loaded     <= 1'b0;
      r_mips_reset <= 1'b1;
      r_mips_en    <= 1'b0;
      r_wrpm       <= 1'b0;
      r_wrdata     <= '0;
      r_wraddr     <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_cycles     <= w_cycles_nxt;
      r_tx_buf     <= w_tx_buf_nxt;
      r_tx_left    <= w_tx_left_nxt;
      r_tx_skip    <= w_tx_skip_nxt;
      r_stepped    <= w_stepped_nxt;
      r_loaded     <= w_loaded_nxt;
      r_mips_reset <= w_mips_reset_nxt;
      r_mips_en    <= w_mips_en_nxt;
      r_wrpm       <= w_wrpm_nxt;
      r_wrdata     <= w_wrdata_nxt;
      r_wraddr     <= w_wraddr_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (I_RX_VALID) begin
          if (I_RX_DATA == CMD_LOAD)      w_state_nxt = S_LOAD_BYTE;
          else if (I_RX_DATA == CMD_RUN)  w_state_nxt = S_RUN;
          else if (I_RX_DATA == CMD_STEP) w_state_nxt = S_STEP;
        end
      end
      S_LOAD_BYTE:  if (I_RX_VALID && r_byte_cnt == 2'd3) w_state_nxt = S_LOAD_WRITE;
      S_LOAD_WRITE: w_state_nxt = w_load_done ? S_TX_SEND : S_LOAD_BYTE;
      S_RUN:        if (I_MIPS_FINISHED) w_state_nxt = S_TX_SEND;
      S_STEP:       if (I_MIPS_FINISHED || r_stepped) w_state_nxt = S_TX_SEND;
      S_TX_SEND:    if (!I_TX_BUSY) w_state_nxt = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!r_tx_skip && !I_TX_BUSY) w_state_nxt = (r_tx_left == 4'd0) ? S_IDLE : S_TX_SEND;
      end
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_word_nxt       = r_word;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_idx_nxt        = r_idx;
    w_cycles_nxt     = r_cycles;
    w_tx_buf_nxt     = r_tx_buf;
    w_tx_left_nxt    = r_tx_left;
    w_tx_skip_nxt    = r_tx_skip;
    w_stepped_nxt    = r_stepped;
    w_loaded_nxt     = r_loaded;
    w_mips_reset_nxt = r_mips_reset;
    w_mips_en_nxt    = 1'b0;
    w_wrpm_nxt       = 1'b0;
    w_wrdata_nxt     = r_wrdata;
    w_wraddr_nxt     = r_wraddr;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    case (r_state)
      S_IDLE: begin
        // Core reset rests high until a load has completed; an 'R' only pulses it.
        w_mips_reset_nxt = ~r_loaded;
        if (I_RX_VALID) begin
          if (I_RX_DATA == CMD_LOAD) begin
            w_mips_reset_nxt = 1'b1;
            w_loaded_nxt     = 1'b0;
            w_idx_nxt        = '0;
            w_byte_cnt_nxt   = '0;
            w_cycles_nxt     = '0;
          end else if (I_RX_DATA == CMD_STEP) begin
            w_stepped_nxt    = 1'b0;
          end else if (I_RX_DATA == CMD_RST) begin
            w_mips_reset_nxt = 1'b1;
            w_cycles_nxt     = '0;
          end
        end
      end
      S_LOAD_BYTE: begin
        if (I_RX_VALID) begin
          w_word_nxt     = w_word_shift;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_wrpm_nxt   = 1'b1;
            w_wrdata_nxt = w_word_shift;
            w_wraddr_nxt = r_idx;
          end
        end
      end
      S_LOAD_WRITE: begin
        w_idx_nxt = w_idx_inc;
        if (w_load_done) begin
          w_mips_reset_nxt = 1'b0;
          w_loaded_nxt     = 1'b1;
          w_tx_buf_nxt     = {w_idx_inc[7:0], 56'd0};
          w_tx_left_nxt    = 4'd1;
        end
      end
      S_RUN: begin
        if (!I_MIPS_FINISHED) begin
          w_mips_en_nxt = 1'b1;
          w_cycles_nxt  = w_cycles_inc;
        end else begin
          w_tx_buf_nxt  = {I_MIPS_PC, r_cycles};
          w_tx_left_nxt = 4'd8;
        end
      end
      S_STEP: begin
        if (I_MIPS_FINISHED || r_stepped) begin
          w_tx_buf_nxt  = {I_MIPS_PC, r_cycles};
          w_tx_left_nxt = 4'd8;
        end else begin
          w_mips_en_nxt = 1'b1;
          w_cycles_nxt  = w_cycles_inc;
          w_stepped_nxt = 1'b1;
        end
      end
      S_TX_SEND: begin
        if (!I_TX_BUSY) begin
          w_tx_data_nxt  = r_tx_buf[63:56];
          w_tx_start_nxt = 1'b1;
          w_tx_buf_nxt   = {r_tx_buf[55:0], 8'd0};
          w_tx_left_nxt  = r_tx_left - 4'd1;
          w_tx_skip_nxt  = 1'b1;
        end
      end
      // The transmitter raises busy only a cycle after the start pulse, so ignore busy for one cycle.
      S_TX_WAIT: if (r_tx_skip) w_tx_skip_nxt = 1'b0;
      default: ;
    endcase
  end

  assign O_TX_DATA           = r_tx_data;
  assign O_TX_START          = r_tx_start;
  assign O_MIPS_RESET        = r_mips_reset;
  assign O_MIPS_EN           = r_mips_en;
  assign O_MIPS_WrPM         = r_wrpm;
  assign O_MIPS_WrDataPM     = r_wrdata;
  assign O_MIPS_WrDataPMAddr = r_wraddr;
  assign O_STATE             = r_state;

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Host-side sequencer for the MIPS2 core. Takes a byte stream from a UART receiver, assembles 32-bit words and writes them into MIPS program memory through the WrPM port.
- Drives the core's reset and clock-enable in continuous or single-step mode.
- After each load, run or step, reports status bytes (PC, executed-cycle count) to a UART transmitter.
- Sits between the UART pair and the MIPS2 top level.

Parameters:
MAX_WORDS, 32, program-memory depth in words; a load stops after this many writes
HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to memory, then the load terminates
CMD_LOAD, 8'h4C, 'L' load program
CMD_RUN, 8'h43, 'C' continuous run
CMD_STEP, 8'h53, 'S' single step
CMD_RST, 8'h52, 'R' reset core

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-high reset
I_RX_DATA  in  8  received byte
I_RX_VALID  in  1  one-cycle strobe, I_RX_DATA valid
I_TX_BUSY  in  1  transmitter busy; rises the cycle after O_TX_START
O_TX_DATA  out  8  byte to transmit
O_TX_START  out  1  one-cycle transmit request
I_MIPS_FINISHED  in  1  core has executed its halt instruction
I_MIPS_PC  in  32  core PC, for reporting
O_MIPS_RESET  out  1  core reset
O_MIPS_EN  out  1  core clock enable; core advances one cycle per high cycle
O_MIPS_WrPM  out  1  program-memory write strobe
O_MIPS_WrDataPM  out  32  program-memory write data
O_MIPS_WrDataPMAddr  out  32  program-memory word address
O_STATE  out  3  current FSM state, for debug

Behaviour:
- Reset values: FSM=IDLE, O_MIPS_RESET=1, O_MIPS_EN=0, O_MIPS_WrPM=0, O_MIPS_WrDataPM=0, O_MIPS_WrDataPMAddr=0, O_TX_START=0, O_TX_DATA=0, cycle counter=0, word index=0, byte counter=0.
- All outputs are registered.
- States and encodings: IDLE 0, LOAD_BYTE 1, LOAD_WRITE 2, RUN 3, STEP 4, TX_SEND 5, TX_WAIT 6.
- IDLE:
  - On I_RX_VALID, decode the byte.
  - L: O_MIPS_RESET=1, word index=0, byte counter=0, cycle counter=0, go to LOAD_BYTE.
  - C: go to RUN.
  - S: go to STEP.
  - R: O_MIPS_RESET=1 for exactly one cycle, cycle counter=0, stay in IDLE, no report.
  - Any other byte is ignored.
- LOAD_BYTE:
  - Bytes arrive MSB first. On each I_RX_VALID the byte shifts into the word register.
  - On the 4th byte, go to LOAD_WRITE.
- LOAD_WRITE (one cycle):
  - O_MIPS_WrPM=1, O_MIPS_WrDataPM=assembled word, O_MIPS_WrDataPMAddr=word index.
  - Next cycle: index+1.
  - If word==HALT_WORD or index+1==MAX_WORDS: O_MIPS_RESET=0 and queue a 1-byte report equal to the number of words written (low 8 bits), then go to TX_SEND.
  - Otherwise return to LOAD_BYTE.
- RUN:
  - O_MIPS_EN=1 every cycle while I_MIPS_FINISHED=0; cycle counter increments per enabled cycle.
  - When I_MIPS_FINISHED=1, O_MIPS_EN drops in that same registered update, and the FSM queues an 8-byte report.
  - If already finished on entry, zero enable cycles occur and the report is sent immediately.
- STEP:
  - O_MIPS_EN=1 for exactly one cycle, counter+1, then queue the 8-byte report.
  - If I_MIPS_FINISHED=1 on entry, no enable cycle occurs and the report is sent.
- 8-byte report order: I_MIPS_PC sampled at report start, MSB first, then the cycle counter MSB first.
- Cycle counter is 32 bits and saturates at 32'hFFFFFFFF.
- TX_SEND:
  - When I_TX_BUSY=0, drive O_TX_DATA and pulse O_TX_START for one cycle, then go to TX_WAIT.
- TX_WAIT:
  - Skip one cycle, then wait for I_TX_BUSY=0.
  - Then either next byte to TX_SEND, or, after the last byte, go to IDLE.
- Bytes received in RUN, STEP, TX_SEND or TX_WAIT are dropped with no side effect.
- O_MIPS_RESET stays 1 from reset until the first completed load. A load-in-progress keeps it 1.
- O_MIPS_WrPM and O_MIPS_EN are never high in the same cycle.
- RESET asserted mid-load or mid-transmit: immediate return to reset values. A partial word is discarded and nothing is written.

Test Plan:
- Load: RESET, then send 4C, 00 00 00 11, 00 00 00 22, FF FF FF FF -> three WrPM pulses at addr 0,1,2 with data 0x11, 0x22, 0xFFFFFFFF; TX byte 0x03; O_MIPS_RESET falls after the 3rd write.
- Load overflow: send 4C followed by 32 non-halt words -> 32 writes at addr 0..31, report byte 0x20, FSM returns to IDLE.
- Step: after load, send 53 twice -> each produces exactly one O_MIPS_EN cycle; second report shows cycle count 0x00000002 and the current PC, MSB first.
- Run: send 43 with I_MIPS_FINISHED forced high 10 enabled cycles later -> exactly 10 EN cycles; report cycle count 0x0000000A; a 53 sent mid-run is dropped.
- Reset and noise: 52 -> one-cycle O_MIPS_RESET pulse, counter cleared; byte 0x99 in IDLE -> no state change, no TX.
- Async reset mid-load: after 4C plus 2 data bytes, assert RESET -> no WrPM; all outputs at reset values; a following full load starts at addr 0.
